// File: rtl/uart_frame_assembler_pkg.sv
// Shared definitions for the UART command frame path.
// Used by the frame assembler and the downstream task state machine.
package uart_frame_assembler_pkg;

   localparam int FRAME_W = 66;
   localparam int PAYLOAD_BYTES = 9;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   localparam int OPC_LSB = 0;
   localparam int OPC_W   = 2;
   localparam int A_LSB   = 2;
   localparam int A_W     = 32;
   localparam int B_LSB   = 34;
   localparam int B_W     = 32;

   typedef enum logic [1:0] {
      HUNT,
      PAYLOAD,
      CHECK,
      HOLD
   } fa_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_frame_assembler_timeout.sv
// Inter-byte idle counter for the frame assembler.
// Restarts on every pop; flags expiry while a frame is in flight.
module byte_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!en_i || clr_i) begin
         cnt_d = '0;
      end
   end

   // Count value k means k clocks have elapsed since the last pop.
   assign expired_o = en_i && (cnt_q == LIMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles sync/payload/checksum byte frames from a UART RX FIFO
// into a 66-bit command held until the consumer acknowledges it.
module uart_frame_assembler
   import uart_frame_assembler_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         rx_data,
   input  logic               rx_empty,
   output logic               rd_uart,
   output logic [FRAME_W-1:0] frame,
   output logic               frame_full,
   input  logic               frame_ack,
   output logic               err_checksum,
   output logic               err_timeout,
   output logic [7:0]         err_count
);

   fa_state_e                   state_q, state_d;
   logic [3:0]                  idx_q, idx_d;
   logic [7:0]                  csum_q, csum_d;
   logic [8*PAYLOAD_BYTES-1:0]  payload_q, payload_d;
   logic [FRAME_W-1:0]          frame_q, frame_d;
   logic                        full_q, full_d;
   logic                        err_ck_q, err_ck_d;
   logic                        err_to_q, err_to_d;
   logic [7:0]                  err_cnt_q, err_cnt_d;

   logic pop;
   logic busy;
   logic expired;
   logic to_hit;

   assign pop  = !rx_empty && (state_q != HOLD);
   assign busy = (state_q == PAYLOAD) || (state_q == CHECK);

   byte_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .en_i     (busy),
      .clr_i    (pop),
      .expired_o(expired)
   );

   // A pop in the expiry cycle keeps the frame alive.
   assign to_hit = busy && !pop && expired;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      payload_d = payload_q;
      frame_d   = frame_q;
      full_d    = full_q;
      err_ck_d  = 1'b0;
      err_to_d  = 1'b0;
      err_cnt_d = err_cnt_q;
      unique case (state_q)
         HUNT: begin
            if (pop && rx_data == SYNC_BYTE) begin
               state_d = PAYLOAD;
               idx_d   = '0;
               csum_d  = '0;
            end
         end
         PAYLOAD: begin
            if (pop) begin
               payload_d[{idx_q, 3'b000} +: 8] = rx_data;
               csum_d = csum_q ^ rx_data;
               if (idx_q == 4'd8) begin
                  state_d = CHECK;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         CHECK: begin
            if (pop) begin
               if (rx_data == csum_q && payload_q[71:66] == '0) begin
                  frame_d = payload_q[FRAME_W-1:0];
                  full_d  = 1'b1;
                  state_d = HOLD;
               end else begin
                  err_ck_d  = 1'b1;
                  err_cnt_d = sat_inc8(err_cnt_q);
                  state_d   = HUNT;
               end
            end
         end
         HOLD: begin
            if (frame_ack) begin
               full_d  = 1'b0;
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
      if (to_hit) begin
         err_to_d  = 1'b1;
         err_cnt_d = sat_inc8(err_cnt_q);
         state_d   = HUNT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= HUNT;
         idx_q     <= '0;
         csum_q    <= '0;
         payload_q <= '0;
         frame_q   <= '0;
         full_q    <= 1'b0;
         err_ck_q  <= 1'b0;
         err_to_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         csum_q    <= csum_d;
         payload_q <= payload_d;
         frame_q   <= frame_d;
         full_q    <= full_d;
         err_ck_q  <= err_ck_d;
         err_to_q  <= err_to_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign rd_uart      = pop;
   assign frame        = frame_q;
   assign frame_full   = full_q;
   assign err_checksum = err_ck_q;
   assign err_timeout  = err_to_q;
   assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler with a FIFO model
// and a queue-based frame parser as reference.
module tb_uart_frame_assembler;
   import uart_frame_assembler_pkg::*;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_empty = 1'b1;
   logic        rd_uart;
   logic [65:0] frame;
   logic        frame_full;
   logic        frame_ack;
   logic        err_checksum;
   logic        err_timeout;
   logic [7:0]  err_count;

   logic ack_man = 1'b0;
   logic ack_auto = 1'b0;
   bit   auto_ack = 1'b0;
   assign frame_ack = auto_ack ? ack_auto : ack_man;

   always #5 clk = ~clk;

   uart_frame_assembler #(
      .SYNC_BYTE     (8'hA5),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_empty    (rx_empty),
      .rd_uart     (rd_uart),
      .frame       (frame),
      .frame_full  (frame_full),
      .frame_ack   (frame_ack),
      .err_checksum(err_checksum),
      .err_timeout (err_timeout),
      .err_count   (err_count)
   );

   int n_tests = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [65:0] act,
                        input logic [65:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef enum int {EV_FRAME, EV_CK, EV_TO} ev_e;
   typedef struct {
      ev_e         kind;
      logic [65:0] f;
      logic [7:0]  cnt;
   } ev_t;

   ev_t        sb[$];
   logic [7:0] fifo[$];
   logic [7:0] mbuf[$];
   bit         hunting = 1'b1;
   int         mcnt = 0;
   int         cyc = 0;
   int         last_pop = -100;

   function automatic void upd();
      rx_empty = (fifo.size() == 0);
      rx_data  = rx_empty ? 8'h00 : fifo[0];
   endfunction

   function automatic void model_err(input ev_e k);
      ev_t e;
      if (mcnt < 255) mcnt++;
      e.kind = k;
      e.f = '0;
      e.cnt = 8'(mcnt);
      sb.push_back(e);
   endfunction

   // Reference: a frame is sync, nine data bytes, then their XOR.
   function automatic void model_feed(input logic [7:0] b);
      logic [71:0] p;
      logic [7:0]  x;
      ev_t         e;
      if (hunting) begin
         if (b == 8'hA5) begin
            hunting = 1'b0;
            mbuf.delete();
         end
         return;
      end
      mbuf.push_back(b);
      if (mbuf.size() == 10) begin
         x = '0;
         p = '0;
         for (int i = 0; i < 9; i++) begin
            x ^= mbuf[i];
            p[i*8 +: 8] = mbuf[i];
         end
         if (x == mbuf[9] && p[71:66] == 6'd0) begin
            e.kind = EV_FRAME;
            e.f = p[65:0];
            e.cnt = 8'(mcnt);
            sb.push_back(e);
         end else begin
            model_err(EV_CK);
         end
         hunting = 1'b1;
      end
   endfunction

   function automatic void model_timeout();
      model_err(EV_TO);
      hunting = 1'b1;
   endfunction

   function automatic void model_reset();
      hunting = 1'b1;
      mbuf.delete();
      mcnt = 0;
      sb.delete();
   endfunction

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      upd();
      model_feed(b);
   endtask

   task automatic push_frame(input logic [71:0] p,
                             input logic [7:0] ck_xor,
                             input int gap);
      logic [7:0] x;
      x = '0;
      push(8'hA5);
      for (int i = 0; i < 9; i++) begin
         x ^= p[i*8 +: 8];
         push(p[i*8 +: 8]);
         if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
      end
      push(x ^ ck_xor);
   endtask

   task automatic push_list(input logic [7:0] l[$]);
      foreach (l[i]) push(l[i]);
   endtask

   // FIFO side: the head byte leaves on every edge where rd_uart is high.
   always @(posedge clk) begin
      cyc++;
      if (rd_uart && !rx_empty) begin
         last_pop = cyc;
         #1;
         void'(fifo.pop_front());
         upd();
      end
   end

   task automatic expect_ev(input ev_e k);
      ev_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got %s expected none", k.name());
      end else begin
         e = sb.pop_front();
         check("event_kind", 66'(k), 66'(e.kind));
         check("event_err_count", 66'(err_count), 66'(e.cnt));
         if (k == EV_FRAME) check("event_frame", frame, e.f);
      end
   endtask

   logic ff_prev = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         ff_prev = 1'b0;
      end else begin
         if (frame_full && !ff_prev) expect_ev(EV_FRAME);
         if (err_checksum) expect_ev(EV_CK);
         if (err_timeout) expect_ev(EV_TO);
         if (frame_full) check("hold_no_pop", 66'(rd_uart), 66'(0));
         ff_prev = frame_full;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (auto_ack && !reset) begin
            if (frame_full) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               ack_auto = 1'b1;
               @(negedge clk);
               ack_auto = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
               ack_auto = 1'b1;
               @(negedge clk);
               ack_auto = 1'b0;
            end
         end
      end
   end

   task automatic wait_full(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (frame_full) begin
            ok = 1'b1;
            break;
         end
      end
      check(nm, 66'(ok), 66'(1));
   endtask

   task automatic do_ack(input string nm);
      ack_man = 1'b1;
      @(negedge clk);
      ack_man = 1'b0;
      check(nm, 66'(frame_full), 66'(0));
   endtask

   task automatic wait_idle(input string nm, input int lim);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (fifo.size() == 0 && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
      check(nm, 66'(ok), 66'(1));
   endtask

   logic [7:0]  l1[$];
   logic [7:0]  l2[$];
   logic [71:0] p;
   logic [65:0] f1;
   bit          ok;

   initial begin
      l1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
      l2 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h01, 8'hFE};
      f1 = 66'h1_0000_0000_FE00_0000;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_frame", frame, 66'd0);
      check("rst_full", 66'(frame_full), 66'(0));
      check("rst_err_ck", 66'(err_checksum), 66'(0));
      check("rst_err_to", 66'(err_timeout), 66'(0));
      check("rst_err_count", 66'(err_count), 66'(0));
      check("rst_rd_uart", 66'(rd_uart), 66'(0));
      reset = 1'b0;
      @(negedge clk);

      // Reference frame and its exact latency.
      push_list(l1);
      wait_full("t1_full_seen");
      check("t1_latency", 66'(cyc - last_pop), 66'(0));
      check("t1_frame", frame, f1);
      check("t1_opcode", 66'(frame[OPC_LSB +: OPC_W]), 66'(0));
      check("t1_opA", 66'(frame[A_LSB +: A_W]), 66'(32'h3F80_0000));
      check("t1_opB", 66'(frame[B_LSB +: B_W]), 66'(32'h4000_0000));
      do_ack("t1_ack_clears");
      check("t1_frame_kept", frame, f1);

      // Wrong checksum, then a good frame.
      push_list(l2);
      wait_idle("t2_idle", 400);
      check("t2_err_count", 66'(err_count), 66'(1));
      check("t2_full", 66'(frame_full), 66'(0));
      check("t2_frame_kept", frame, f1);
      p = 72'h00_1234_5678_9ABC_DEF0;
      push_frame(p, 8'h00, 0);
      wait_full("t2_next_full");
      check("t2_next_frame", frame, p[65:0]);
      do_ack("t2_ack");

      // Reserved high payload bits set with a correct XOR.
      p = 72'h05_0102_0304_0506_0708;
      push_frame(p, 8'h00, 0);
      wait_idle("t3_idle", 400);
      check("t3_err_count", 66'(err_count), 66'(2));
      check("t3_full", 66'(frame_full), 66'(0));

      // Leading garbage is skipped.
      push(8'h12);
      push(8'h34);
      p = 72'h03_CAFE_BABE_0BAD_F00D;
      push_frame(p, 8'h00, 0);
      wait_full("t4_full");
      check("t4_frame", frame, p[65:0]);
      do_ack("t4_ack");

      // Stall after four payload bytes.
      push(8'hA5);
      for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
      model_timeout();
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (err_timeout) begin
            ok = 1'b1;
            break;
         end
      end
      check("t5_timeout_seen", 66'(ok), 66'(1));
      check("t5_timeout_delay", 66'(cyc - last_pop), 66'(TO));
      @(negedge clk);
      check("t5_pulse_one", 66'(err_timeout), 66'(0));
      check("t5_err_count", 66'(err_count), 66'(3));
      p = 72'h01_A5A5_A5A5_A5A5_A5A5;
      push_frame(p, 8'h00, 0);
      wait_full("t5_resync_full");
      check("t5_frame", frame, p[65:0]);
      do_ack("t5_ack");

      // Second frame waits in the FIFO during HOLD.
      p = 72'h02_1111_2222_3333_4444;
      push_frame(p, 8'h00, 0);
      push_frame(72'h00_5555_6666_7777_8888, 8'h00, 0);
      wait_full("t6_first_full");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t6_hold_rd", 66'(rd_uart), 66'(0));
         check("t6_hold_fifo", 66'(fifo.size()), 66'(11));
      end
      do_ack("t6_first_ack");
      wait_full("t6_second_full");
      check("t6_second_frame", frame, 66'h0_5555_6666_7777_8888);
      do_ack("t6_second_ack");
      wait_idle("t6_idle", 400);

      // Randomised traffic with automatic acknowledge.
      auto_ack = 1'b1;
      for (int f = 0; f < 40; f++) begin
         logic [7:0] g;
         logic [7:0] cx;
         repeat ($urandom_range(0, 2)) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            push(g);
         end
         p = {8'($urandom), 32'($urandom), 32'($urandom)};
         if ($urandom_range(0, 7) != 0) p[71:66] = 6'd0;
         cx = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         push_frame(p, cx, 2);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle("rand_idle", 20000);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!frame_full) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rand_released", 66'(ok), 66'(1));
      repeat (3) @(negedge clk);
      auto_ack = 1'b0;
      @(negedge clk);

      // Reset in the middle of a frame.
      push(8'hA5);
      for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fifo.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("t8_drained", 66'(ok), 66'(1));
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check("t8_frame", frame, 66'd0);
      check("t8_full", 66'(frame_full), 66'(0));
      check("t8_err_ck", 66'(err_checksum), 66'(0));
      check("t8_err_to", 66'(err_timeout), 66'(0));
      check("t8_err_count", 66'(err_count), 66'(0));
      check("t8_rd_uart", 66'(rd_uart), 66'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      p = 72'h01_0F0F_0F0F_F0F0_F0F0;
      push_frame(p, 8'h00, 0);
      wait_full("t8_after_full");
      check("t8_after_frame", frame, p[65:0]);
      do_ack("t8_ack");
      repeat (TO + 4) @(negedge clk);
      check("t8_no_late_err", 66'(err_count), 66'(0));

      check("sb_empty", 66'(sb.size()), 66'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_frame_assembler.md
UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

Interface
REQ-001 SHALL provide parameter SYNC_BYTE, default 8'hA5, the frame header byte.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 1_000_000, the maximum idle clocks between bytes inside a frame.
REQ-003 SHALL use clock clk, and reset reset (asynchronous, active-high).
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  head byte of the show-ahead UART RX FIFO; valid whenever rx_empty=0
- rx_empty  in  1  RX FIFO empty
- rd_uart  out  1  FIFO pop; the byte on rx_data is consumed in the cycle rd_uart=1
- frame  out  66  assembled command: [1:0] opcode, [33:2] operand A, [65:34] operand B
- frame_full  out  1  frame is valid and held for the downstream task state machine
- frame_ack  in  1  downstream has taken the frame
- err_checksum  out  1  one-cycle pulse on a rejected frame
- err_timeout  out  1  one-cycle pulse on an inter-byte timeout
- err_count  out  8  saturating count of all errors

Function
REQ-005 SHALL implement states HUNT, PAYLOAD, CHECK and HOLD.
REQ-006 SHALL drive rd_uart combinationally as (rx_empty=0) AND (state != HOLD).
REQ-007 In HUNT, SHALL discard every consumed byte except SYNC_BYTE; on SYNC_BYTE it SHALL go to PAYLOAD with byte index 0 and running checksum 0.
REQ-008 In PAYLOAD, SHALL store consumed byte k (k = 0..8, little-endian) into payload bits [8k+7:8k] and XOR it into the running checksum; after k=8 it SHALL go to CHECK.
REQ-009 In CHECK, the consumed byte is the checksum. If it equals the running checksum AND payload bits [71:66] are 0, SHALL load frame <= payload[65:0], set frame_full=1 and go to HOLD. Otherwise SHALL pulse err_checksum, increment err_count and go to HUNT.
REQ-010 frame_full SHALL rise in the cycle after the checksum byte is consumed (latency 1 clock).
REQ-011 In HOLD, SHALL keep frame stable and pop nothing. On frame_ack=1, frame_full SHALL be 0 from the next cycle and the state SHALL return to HUNT.
REQ-012 frame_ack SHALL be ignored outside HOLD.
REQ-013 frame SHALL change only on a validated frame; it keeps its last value after acknowledge.
REQ-014 In PAYLOAD and CHECK, a counter SHALL count clocks since the last consumed byte and restart at 0 on each pop. When it reaches TIMEOUT_CYCLES, SHALL pulse err_timeout, increment err_count, discard the partial frame and go to HUNT.
REQ-015 No timeout SHALL apply in HUNT or HOLD.
REQ-016 err_count SHALL saturate at 255.
REQ-017 If a timeout and a byte pop occur in the same cycle, the pop SHALL win: the byte is processed and the counter restarts.
REQ-018 A SYNC_BYTE value arriving inside PAYLOAD SHALL be treated as ordinary data (no resync).

Reset
REQ-019 Reset SHALL set state=HUNT, frame=0, frame_full=0, err_checksum=0, err_timeout=0, err_count=0, index=0, checksum=0 and timeout counter=0.
REQ-020 Reset asserted mid-frame or in HOLD SHALL abandon the frame with no error pulse.

Structure
REQ-021 State encodings, SYNC_BYTE default, frame field positions (opcode [1:0], A [33:2], B [65:34]) and the frame width of 66 SHALL live in a shared package used by both this block and the task state machine.
REQ-022 The timeout counter SHALL be a sub-module, byte_timeout_counter; all other logic is flat.

Verification
REQ-023 Stream A5 00 00 00 FE 00 00 00 00 01 FF -> frame=66'h1_0000_0000_FE00_0000 (opcode 0, A=32'h3F800000, B=32'h40000000), frame_full=1 one clock after FF is popped; frame_ack -> frame_full=0 on the next cycle.
REQ-024 Same stream with checksum FE -> err_checksum pulses once, err_count=1, frame_full stays 0, and the next valid frame is accepted.
REQ-025 Payload byte 8 = 8'h05 with a correct XOR checksum -> rejected (bits [71:66] nonzero), err_count increments.
REQ-026 Leading garbage 12 34 followed by a valid frame -> garbage discarded, frame accepted.
REQ-027 With TIMEOUT_CYCLES=16, stop the stream after 4 payload bytes -> err_timeout pulses 16 clocks after the last pop, state=HUNT.
REQ-028 Second frame queued in the FIFO while in HOLD -> rd_uart stays 0 until frame_ack; then the second frame is assembled; assert reset mid-frame -> all outputs return to 0.
